mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- memory-access stage of the five-stage integer pipeline.
//
// Captures the execute-stage result, classifies it as a load, a store or a
// non-memory op, checks the alignment of the access and raises the address
// error exceptions. A small IDLE -> REQ -> DONE machine carries out at most one
// data-bus transaction per latched op. Load data is extracted, sign- or
// zero-extended, and returned on m_val.
//
// Ports
//   clk, resetn            clock (rising edge) and synchronous active-low reset
//   e_pc, e_val3, e_valt   execute-stage PC, ALU result / address, store data
//   e_icode, e_acode       instruction code and ALU code
//   e_excCode, e_dst       incoming exception code and destination register
//   e_inDelaySlot          op sits in a branch delay slot
//   M_bubble, M_stall      hazard-unit controls for this stage
//   dreq_*                 data-bus request (valid/write/addr/strobe/data)
//   dresp_ok, dresp_data   data-bus response
//   m_pc, m_val, m_icode   stage outputs to write-back
//   m_excCode, m_dst       resolved exception code and destination register
//   m_inDelaySlot          delay-slot flag passed through
//   m_busy                 bus transaction pending, upstream must stall
//   m_badvaddr             faulting address of an address error
//
// Configuration
//   MEM_STAGE_BADVADDR_EN  when defined, m_badvaddr reports (and remembers) the
//                          address of the most recent AdEL/AdES; otherwise it
//                          is tied to zero and no register is built for it.
// -----------------------------------------------------------------------------
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] e_pc,
  input  logic [31:0] e_val3,
  input  logic [31:0] e_valt,
  input  logic [5:0]  e_icode,
  input  logic [5:0]  e_acode,
  input  logic [5:0]  e_excCode,
  input  logic [4:0]  e_dst,
  input  logic        e_inDelaySlot,
  input  logic        M_bubble,
  input  logic        M_stall,
  output logic        dreq_valid,
  output logic        dreq_write,
  output logic [31:0] dreq_addr,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_ok,
  input  logic [31:0] dresp_data,
  output logic [31:0] m_pc,
  output logic [31:0] m_val,
  output logic [5:0]  m_icode,
  output logic [5:0]  m_excCode,
  output logic [4:0]  m_dst,
  output logic        m_inDelaySlot,
  output logic        m_busy,
  output logic [31:0] m_badvaddr
);

  // Opcode constants shared with the decode stage.
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [5:0] EXC_ADEL = 6'b100100;
  localparam logic [5:0] EXC_ADES = 6'b100101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Data helpers
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] load_extract(input logic [5:0]  icode,
                                               input logic [1:0]  off,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (icode)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'h0, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_strobe(input logic [5:0] icode,
                                              input logic [1:0] off);
    logic [3:0] s;
    case (icode)
      OP_SW:   s = 4'b1111;
      OP_SH:   s = 4'b0011 << off;
      OP_SB:   s = 4'b0001 << off;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  // Sub-word stores replicate the payload so the byte lanes selected by the
  // strobe always carry the right bytes regardless of the offset.
  function automatic logic [31:0] store_data(input logic [5:0]  icode,
                                             input logic [31:0] valt);
    logic [31:0] d;
    case (icode)
      OP_SW:   d = valt;
      OP_SH:   d = {2{valt[15:0]}};
      OP_SB:   d = {4{valt[7:0]}};
      default: d = 32'h0;
    endcase
    return d;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  logic [31:0] pc_q,    pc_d;
  logic [31:0] val3_q,  val3_d;
  logic [31:0] valt_q,  valt_d;
  logic [5:0]  icode_q, icode_d;
  logic [5:0]  acode_q, acode_d;
  logic [5:0]  exc_q,   exc_d;
  logic [4:0]  dst_q,   dst_d;
  logic        ds_q,    ds_d;
  // Set when a fresh op is latched, cleared once its bus request has started,
  // so an op that stays in the stage (stall) is never sent to the bus twice.
  logic        pend_q,  pend_d;

  state_t      state_q;
  logic        dreq_valid_q;
  logic [31:0] rdata_q;

  logic        is_load, is_store, is_word, is_half;
  logic        misalign;
  logic        need_req;

  // A bubble or a new latch is only honoured while no transaction is pending,
  // so a bubble can never abort an outstanding request.
  always_comb begin
    pc_d    = pc_q;
    val3_d  = val3_q;
    valt_d  = valt_q;
    icode_d = icode_q;
    acode_d = acode_q;
    exc_d   = exc_q;
    dst_d   = dst_q;
    ds_d    = ds_q;
    pend_d  = pend_q;
    if (m_busy) begin
      // Busy means either the request is being launched now or already is.
      pend_d = 1'b0;
    end else if (M_bubble) begin
      val3_d  = '0;
      valt_d  = '0;
      icode_d = '0;
      acode_d = '0;
      exc_d   = '0;
      dst_d   = '0;
      ds_d    = 1'b0;
      pend_d  = 1'b0;
    end else if (!M_stall) begin
      pc_d    = e_pc;
      val3_d  = e_val3;
      valt_d  = e_valt;
      icode_d = e_icode;
      acode_d = e_acode;
      exc_d   = e_excCode;
      dst_d   = e_dst;
      ds_d    = e_inDelaySlot;
      pend_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q    <= '0;
      val3_q  <= '0;
      valt_q  <= '0;
      icode_q <= '0;
      acode_q <= '0;
      exc_q   <= '0;
      dst_q   <= '0;
      ds_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      val3_q  <= val3_d;
      valt_q  <= valt_d;
      icode_q <= icode_d;
      acode_q <= acode_d;
      exc_q   <= exc_d;
      dst_q   <= dst_d;
      ds_q    <= ds_d;
      pend_q  <= pend_d;
    end
  end

  // The ALU code has no role in this stage; it is carried only so the stage
  // registers stay a faithful copy of the execute-stage outputs.
  logic unused_acode;
  assign unused_acode = ^acode_q;

  // ---------------------------------------------------------------------------
  // Classification and exception resolution
  // ---------------------------------------------------------------------------
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_word  = 1'b0;
    is_half  = 1'b0;
    case (icode_q)
      OP_LW:          begin is_load  = 1'b1; is_word = 1'b1; end
      OP_LH, OP_LHU:  begin is_load  = 1'b1; is_half = 1'b1; end
      OP_LB, OP_LBU:  begin is_load  = 1'b1;                 end
      OP_SW:          begin is_store = 1'b1; is_word = 1'b1; end
      OP_SH:          begin is_store = 1'b1; is_half = 1'b1; end
      OP_SB:          begin is_store = 1'b1;                 end
      default:        ;
    endcase
  end

  assign misalign = (is_word && (val3_q[1:0] != 2'b00)) || (is_half && val3_q[0]);

  // An exception raised upstream takes precedence over an alignment fault.
  always_comb begin
    if (exc_q[5]) begin
      m_excCode = exc_q;
    end else if (misalign && is_load) begin
      m_excCode = EXC_ADEL;
    end else if (misalign && is_store) begin
      m_excCode = EXC_ADES;
    end else begin
      m_excCode = 6'h0;
    end
  end

  assign need_req = pend_q && (is_load || is_store) && !m_excCode[5];

  // ---------------------------------------------------------------------------
  // Bus transaction FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      dreq_valid_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (need_req) begin
            state_q      <= S_REQ;
            dreq_valid_q <= 1'b1;
          end
        end
        S_REQ: begin
          if (dresp_ok) begin
            rdata_q      <= dresp_data;
            state_q      <= S_DONE;
            dreq_valid_q <= 1'b0;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q      <= S_IDLE;
          dreq_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Busy is raised combinationally in IDLE so upstream stalls in the very
  // cycle after the op is latched; it drops in DONE so the next op can enter.
  assign m_busy = (state_q == S_REQ) || ((state_q == S_IDLE) && need_req);

  // Request fields come straight from the stage registers, which are frozen
  // while busy, so they stay stable for the whole request.
  assign dreq_valid  = dreq_valid_q;
  assign dreq_write  = is_store;
  assign dreq_addr   = val3_q;
  assign dreq_strobe = store_strobe(icode_q, val3_q[1:0]);
  assign dreq_data   = store_data(icode_q, valt_q);

  // ---------------------------------------------------------------------------
  // Stage outputs
  // ---------------------------------------------------------------------------
  assign m_pc          = pc_q;
  assign m_icode       = icode_q;
  assign m_inDelaySlot = ds_q;
  assign m_val         = (is_load && !m_excCode[5])
                         ? load_extract(icode_q, val3_q[1:0], rdata_q)
                         : val3_q;
  assign m_dst         = (m_excCode[5] || is_store) ? 5'h0 : dst_q;

`ifdef MEM_STAGE_BADVADDR_EN
  logic [31:0] badvaddr_q;
  logic        adex;

  assign adex = (m_excCode == EXC_ADEL) || (m_excCode == EXC_ADES);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      badvaddr_q <= '0;
    end else if (adex) begin
      badvaddr_q <= val3_q;
    end
  end

  // Show the faulting address in the same cycle the fault is raised, and keep
  // reporting it afterwards until the next address error.
  assign m_badvaddr = adex ? val3_q : badvaddr_q;
`else
  assign m_badvaddr = 32'h0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  localparam logic [5:0] OP_ADD = 6'h01;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] ADEL   = 6'b100100;
  localparam logic [5:0] ADES   = 6'b100101;
`ifdef MEM_STAGE_BADVADDR_EN
  localparam bit BAD_EN = 1'b1;
`else
  localparam bit BAD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] e_pc = '0, e_val3 = '0, e_valt = '0;
  logic [5:0]  e_icode = '0, e_acode = '0, e_excCode = '0;
  logic [4:0]  e_dst = '0;
  logic        e_inDelaySlot = 1'b0;
  logic        M_bubble = 1'b1, M_stall = 1'b0;
  logic        dreq_valid, dreq_write;
  logic [31:0] dreq_addr, dreq_data;
  logic [3:0]  dreq_strobe;
  logic        rsp_ok = 1'b0, late_ok = 1'b0;
  logic [31:0] rsp_data = '0;
  logic [31:0] m_pc, m_val, m_badvaddr;
  logic [5:0]  m_icode, m_excCode;
  logic [4:0]  m_dst;
  logic        m_inDelaySlot, m_busy;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .resetn(resetn),
    .e_pc(e_pc), .e_val3(e_val3), .e_valt(e_valt),
    .e_icode(e_icode), .e_acode(e_acode), .e_excCode(e_excCode),
    .e_dst(e_dst), .e_inDelaySlot(e_inDelaySlot),
    .M_bubble(M_bubble), .M_stall(M_stall),
    .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_ok(rsp_ok | late_ok), .dresp_data(rsp_data),
    .m_pc(m_pc), .m_val(m_val), .m_icode(m_icode), .m_excCode(m_excCode),
    .m_dst(m_dst), .m_inDelaySlot(m_inDelaySlot), .m_busy(m_busy),
    .m_badvaddr(m_badvaddr)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  icode;
    logic [31:0] val;
    logic [5:0]  exc;
    logic [4:0]  dst;
    logic        ds;
    logic [31:0] bad;
    logic [7:0]  busy;
  } ret_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic        chk_data;
    logic [31:0] data;
  } bus_t;

  typedef struct packed {
    logic [7:0]  wt;
    logic [31:0] data;
  } rsp_t;

  ret_t ret_q[$];
  bus_t bus_q[$];
  rsp_t rsp_q[$];

  int errors = 0;
  int checks = 0;
  logic [31:0] bad_hold = '0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    checks++;
    if (|{dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_data, m_pc, m_val,
          m_icode, m_excCode, m_dst, m_inDelaySlot, m_busy, m_badvaddr} !== 1'b0) begin
      errors++;
      $display("FAIL %s: got valid=%b pc=%h val=%h icode=%h exc=%h dst=%h busy=%b bad=%h expected all zero",
               name, dreq_valid, m_pc, m_val, m_icode, m_excCode, m_dst, m_busy, m_badvaddr);
    end
  endtask

  // Expected retirement of one op; badvaddr follows the last address error
  // when the feature is built in, and is zero otherwise.
  task automatic push_ret(input logic [31:0] pc, input logic [5:0] icode,
                          input logic [31:0] val, input logic [5:0] exc,
                          input logic [4:0] dst, input logic ds,
                          input logic [31:0] addr, input logic [7:0] busy);
    ret_t e;
    if (BAD_EN && (exc == ADEL || exc == ADES)) bad_hold = addr;
    e.pc = pc; e.icode = icode; e.val = val; e.exc = exc; e.dst = dst;
    e.ds = ds; e.bad = bad_hold; e.busy = busy;
    ret_q.push_back(e);
  endtask

  task automatic push_bus(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                          input logic chk_data, input logic [31:0] data,
                          input logic [7:0] wt, input logic [31:0] rdata);
    bus_t b;
    rsp_t r;
    b.wr = wr; b.addr = addr; b.strb = strb; b.chk_data = chk_data; b.data = data;
    r.wt = wt; r.data = rdata;
    bus_q.push_back(b);
    rsp_q.push_back(r);
  endtask

  // Present an op and wait until the stage has taken it.
  task automatic issue(input logic [5:0] icode, input logic [31:0] pc, input logic [31:0] val3,
                       input logic [31:0] valt, input logic [4:0] dst, input logic [5:0] exc,
                       input logic ds);
    int n;
    e_icode = icode; e_pc = pc; e_val3 = val3; e_valt = valt; e_dst = dst;
    e_excCode = exc; e_inDelaySlot = ds; e_acode = 6'h15;
    M_bubble = 1'b0; M_stall = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_busy && n < 200);
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL issue_timeout: pc %h still waiting after %0d cycles, required accept", pc, n);
    end
    @(posedge clk);
    #1;
    M_bubble = 1'b1;
  endtask

  // Retirement monitor: an op is complete when a new PC is shown while not busy.
  logic [31:0] last_pc = '0;
  int          busy_cnt = 0;
  always @(negedge clk) begin
    ret_t e;
    if (!resetn) begin
      busy_cnt = 0;
    end else if (m_busy) begin
      busy_cnt++;
    end else if (m_pc != last_pc && m_pc != 32'h0) begin
      last_pc = m_pc;
      if (ret_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL retire_unexpected: got pc %h, required no retirement", m_pc);
      end else begin
        e = ret_q.pop_front();
        chk("ret_pc",    {40'h0, m_pc},          {40'h0, e.pc});
        chk("ret_icode", {66'h0, m_icode},       {66'h0, e.icode});
        chk("ret_val",   {40'h0, m_val},         {40'h0, e.val});
        chk("ret_exc",   {66'h0, m_excCode},     {66'h0, e.exc});
        chk("ret_dst",   {67'h0, m_dst},         {67'h0, e.dst});
        chk("ret_ds",    {71'h0, m_inDelaySlot}, {71'h0, e.ds});
        chk("ret_bad",   {40'h0, m_badvaddr},    {40'h0, e.bad});
        chk("ret_busy",  {40'h0, busy_cnt[31:0]}, {64'h0, e.busy});
      end
      busy_cnt = 0;
    end
  end

  // Bus monitor: checks each new request and its stability while valid.
  logic        prev_v = 1'b0;
  logic [68:0] cur_req = '0;
  always @(negedge clk) begin
    bus_t b;
    if (dreq_valid) begin
      if (!prev_v) begin
        if (bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL bus_unexpected: got request addr %h, required none", dreq_addr);
        end else begin
          b = bus_q.pop_front();
          chk("bus_write",  {71'h0, dreq_write},  {71'h0, b.wr});
          chk("bus_addr",   {40'h0, dreq_addr},   {40'h0, b.addr});
          chk("bus_strobe", {68'h0, dreq_strobe}, {68'h0, b.strb});
          if (b.chk_data) chk("bus_data", {40'h0, dreq_data}, {40'h0, b.data});
        end
        cur_req = {dreq_write, dreq_addr, dreq_strobe, dreq_data};
      end else begin
        chk("bus_stable", {3'h0, dreq_write, dreq_addr, dreq_strobe, dreq_data}, {3'h0, cur_req});
      end
    end
    prev_v = dreq_valid;
  end

  // Memory responder: acknowledges after the programmed number of wait cycles.
  logic rsp_act = 1'b0;
  int   rsp_cnt = 0;
  rsp_t rcur = '0;
  always @(negedge clk) begin
    if (dreq_valid) begin
      if (!rsp_act) begin
        rsp_act = 1'b1;
        rsp_cnt = 0;
        rcur = (rsp_q.size() != 0) ? rsp_q.pop_front() : '0;
      end
      if (rsp_cnt == int'(rcur.wt)) begin
        rsp_ok = 1'b1;
        rsp_data = rcur.data;
      end else begin
        rsp_ok = 1'b0;
      end
      rsp_cnt++;
    end else begin
      rsp_act = 1'b0;
      rsp_ok = 1'b0;
    end
  end

  initial begin
    int n;
    // Reset state
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset_state");
    resetn = 1'b1;
    @(posedge clk); #1;

    // Non-memory op
    push_ret(32'h100, OP_ADD, 32'hDEAD0001, 6'h0, 5'd3, 1'b1, 32'hDEAD0001, 8'd0);
    issue(OP_ADD, 32'h100, 32'hDEAD0001, 32'h0, 5'd3, 6'h0, 1'b1);
    // LW with two wait cycles
    push_bus(1'b0, 32'h80000004, 4'b0000, 1'b0, 32'h0, 8'd2, 32'h12345678);
    push_ret(32'h104, OP_LW, 32'h12345678, 6'h0, 5'd5, 1'b0, 32'h80000004, 8'd4);
    issue(OP_LW, 32'h104, 32'h80000004, 32'h0, 5'd5, 6'h0, 1'b0);
    // LB / LBU of the top byte
    push_bus(1'b0, 32'h80000003, 4'b0000, 1'b0, 32'h0, 8'd0, 32'h80AABBCC);
    push_ret(32'h108, OP_LB, 32'hFFFFFF80, 6'h0, 5'd6, 1'b0, 32'h80000003, 8'd2);
    issue(OP_LB, 32'h108, 32'h80000003, 32'h0, 5'd6, 6'h0, 1'b0);
    push_bus(1'b0, 32'h80000003, 4'b0000, 1'b0, 32'h0, 8'd0, 32'h80AABBCC);
    push_ret(32'h10C, OP_LBU, 32'h00000080, 6'h0, 5'd6, 1'b0, 32'h80000003, 8'd2);
    issue(OP_LBU, 32'h10C, 32'h80000003, 32'h0, 5'd6, 6'h0, 1'b0);
    // SH to the upper halfword
    push_bus(1'b1, 32'h80000002, 4'b1100, 1'b1, 32'hBEEFBEEF, 8'd1, 32'h0);
    push_ret(32'h110, OP_SH, 32'h80000002, 6'h0, 5'd0, 1'b0, 32'h80000002, 8'd3);
    issue(OP_SH, 32'h110, 32'h80000002, 32'h0000BEEF, 5'd7, 6'h0, 1'b0);
    // LH upper / LHU lower halfword
    push_bus(1'b0, 32'h80000002, 4'b0000, 1'b0, 32'h0, 8'd0, 32'h80AABBCC);
    push_ret(32'h114, OP_LH, 32'hFFFF80AA, 6'h0, 5'd8, 1'b0, 32'h80000002, 8'd2);
    issue(OP_LH, 32'h114, 32'h80000002, 32'h0, 5'd8, 6'h0, 1'b0);
    push_bus(1'b0, 32'h80000000, 4'b0000, 1'b0, 32'h0, 8'd0, 32'h80AABBCC);
    push_ret(32'h118, OP_LHU, 32'h0000BBCC, 6'h0, 5'd9, 1'b0, 32'h80000000, 8'd2);
    issue(OP_LHU, 32'h118, 32'h80000000, 32'h0, 5'd9, 6'h0, 1'b0);
    // SB at byte 1
    push_bus(1'b1, 32'h80000001, 4'b0010, 1'b1, 32'hA5A5A5A5, 8'd0, 32'h0);
    push_ret(32'h11C, OP_SB, 32'h80000001, 6'h0, 5'd0, 1'b0, 32'h80000001, 8'd2);
    issue(OP_SB, 32'h11C, 32'h80000001, 32'h123456A5, 5'd10, 6'h0, 1'b0);
    // SW with three wait cycles
    push_bus(1'b1, 32'h80000008, 4'b1111, 1'b1, 32'hCAFEF00D, 8'd3, 32'h0);
    push_ret(32'h120, OP_SW, 32'h80000008, 6'h0, 5'd0, 1'b0, 32'h80000008, 8'd5);
    issue(OP_SW, 32'h120, 32'h80000008, 32'hCAFEF00D, 5'd11, 6'h0, 1'b0);
    // Byte load at an odd address is legal
    push_bus(1'b0, 32'h80000001, 4'b0000, 1'b0, 32'h0, 8'd0, 32'h11227F33);
    push_ret(32'h124, OP_LB, 32'h0000007F, 6'h0, 5'd12, 1'b0, 32'h80000001, 8'd2);
    issue(OP_LB, 32'h124, 32'h80000001, 32'h0, 5'd12, 6'h0, 1'b0);
    // Misaligned LW -> AdEL, misaligned SH -> AdES, no requests
    push_ret(32'h128, OP_LW, 32'h80000001, ADEL, 5'd0, 1'b0, 32'h80000001, 8'd0);
    issue(OP_LW, 32'h128, 32'h80000001, 32'h0, 5'd13, 6'h0, 1'b0);
    push_ret(32'h12C, OP_SH, 32'h80000003, ADES, 5'd0, 1'b1, 32'h80000003, 8'd0);
    issue(OP_SH, 32'h12C, 32'h80000003, 32'h1, 5'd14, 6'h0, 1'b1);
    // Following non-memory op: badvaddr keeps the last fault address
    push_ret(32'h130, OP_ADD, 32'h00000005, 6'h0, 5'd2, 1'b0, 32'h5, 8'd0);
    issue(OP_ADD, 32'h130, 32'h5, 32'h0, 5'd2, 6'h0, 1'b0);

    // Stall holds the stage; bubble beats stall but keeps the PC
    e_icode = OP_SW; e_pc = 32'h134; e_val3 = 32'h80000010; e_excCode = 6'b101100;
    M_bubble = 1'b0; M_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_hold_pc", {40'h0, m_pc}, {40'h0, 32'h130});
    end
    M_bubble = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bubble_state", {40'h0, m_icode, m_dst, m_excCode, m_inDelaySlot, m_val[8:0]}, 72'h0);
    chk("bubble_pc", {40'h0, m_pc}, {40'h0, 32'h130});
    @(posedge clk); #1;
    // Upstream exception on SW passes through, no request
    push_ret(32'h134, OP_SW, 32'h80000010, 6'b101100, 5'd0, 1'b0, 32'h80000010, 8'd0);
    issue(OP_SW, 32'h134, 32'h80000010, 32'h77, 5'd15, 6'b101100, 1'b0);

    // Reset while a request is outstanding; a late response is ignored
    push_bus(1'b0, 32'h80000020, 4'b0000, 1'b0, 32'h0, 8'd20, 32'hFFFFFFFF);
    issue(OP_LW, 32'h300, 32'h80000020, 32'h0, 5'd1, 6'h0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dreq_valid && n < 50);
    chk("reset_req_seen", {71'h0, dreq_valid}, 72'h1);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset_in_req");
    resetn = 1'b1;
    bad_hold = '0;
    late_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_ok_ignored", {38'h0, dreq_valid, m_busy, m_val}, 72'h0);
    end
    late_ok = 1'b0;
    @(posedge clk); #1;

    // Recovery after reset
    push_bus(1'b0, 32'h80000024, 4'b0000, 1'b0, 32'h0, 8'd0, 32'h0BADF00D);
    push_ret(32'h304, OP_LW, 32'h0BADF00D, 6'h0, 5'd4, 1'b0, 32'h80000024, 8'd2);
    issue(OP_LW, 32'h304, 32'h80000024, 32'h0, 5'd4, 6'h0, 1'b0);

    n = 0;
    while (ret_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("retire_queue_empty", {40'h0, 32'(ret_q.size())}, 72'h0);
    chk("bus_queue_empty",    {40'h0, 32'(bus_q.size())}, 72'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
